// File: rtl/result_buffer.sv
// result_buffer: single-clock, BRAM-backed result FIFO between the compute
// engine and the host read path. Optional first-word-fall-through read port,
// synchronous flush, almost-full/almost-empty flags and sticky error flags.
module result_buffer #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned DEPTH            = 4096,
    parameter int unsigned AFULL_THRESHOLD  = DEPTH - 256,
    parameter int unsigned AEMPTY_THRESHOLD = 4,
    parameter bit          FWFT             = 1'b0,
    parameter int unsigned COUNT_WIDTH      = $clog2(DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    input  logic                   i_wr_en,
    output logic                   o_full,
    output logic                   o_afull,
    input  logic                   i_rd_en,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_empty,
    output logic                   o_aempty,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_overflow,
    output logic                   o_underflow,
    input  logic                   i_clr_err
);

    localparam int unsigned PtrWidth = $clog2(DEPTH);

    localparam logic [COUNT_WIDTH-1:0] FullLevel   = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AfullLevel  = COUNT_WIDTH'(AFULL_THRESHOLD);
    localparam logic [COUNT_WIDTH-1:0] AemptyLevel = COUNT_WIDTH'(AEMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
    // count_q: every word held; mem_count_q: words still in the RAM array.
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] mem_count_q, mem_count_d;

    // RAM output register: the read-data register in standard mode, the
    // prefetch stage in FWFT mode.
    logic                   pf_valid_q, pf_valid_d;
    logic [DATA_WIDTH-1:0]  pf_data_q;
    // FWFT output stage (unused in standard mode).
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic full_q, full_d;
    logic afull_q, afull_d;
    logic empty_q, empty_d;
    logic aempty_q, aempty_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic wr_acc, rd_acc, mem_rd;
    logic out_free, pf_move, pf_free;
    logic overflow_set, underflow_set;

    // Acceptance, pipeline movement and next-state computation.
    always_comb begin
        wr_acc = i_wr_en & ~full_q & ~i_flush;
        if (FWFT) begin
            rd_acc = i_rd_en & out_valid_q & ~i_flush;
        end else begin
            rd_acc = i_rd_en & ~empty_q & ~i_flush;
        end

        // FWFT: prefetch feeds the output stage whenever it is empty or being
        // popped, and the RAM refills the prefetch stage in the same cycle.
        out_free = ~out_valid_q | rd_acc;
        pf_move  = FWFT & pf_valid_q & out_free;
        pf_free  = ~pf_valid_q | pf_move;
        if (FWFT) begin
            mem_rd = (mem_count_q != '0) & pf_free & ~i_flush;
        end else begin
            mem_rd = rd_acc;
        end

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_count_d = mem_count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (mem_rd) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end

        if (wr_acc && !mem_rd) begin
            mem_count_d = mem_count_q + COUNT_WIDTH'(1);
        end else if (!wr_acc && mem_rd) begin
            mem_count_d = mem_count_q - COUNT_WIDTH'(1);
        end

        if (FWFT) begin
            pf_valid_d  = mem_rd | (pf_valid_q & ~pf_move);
            out_valid_d = pf_move | (out_valid_q & ~rd_acc);
        end else begin
            // Standard mode: read-valid is a one-cycle strobe per accepted read.
            pf_valid_d  = mem_rd;
            out_valid_d = 1'b0;
        end
        out_data_d = pf_move ? pf_data_q : out_data_q;

        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            mem_count_d = '0;
            pf_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end

        // Flags track the next-state count so they never lag o_count.
        full_d   = (count_d == FullLevel);
        afull_d  = (count_d >= AfullLevel);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= AemptyLevel);

        // Set beats clear when both happen in the same cycle.
        overflow_set  = i_wr_en & full_q & ~i_flush;
        underflow_set = i_rd_en & ~rd_acc & ~i_flush;
        overflow_d    = overflow_set | (overflow_q & ~i_clr_err);
        underflow_d   = underflow_set | (underflow_q & ~i_clr_err);
    end

    // RAM write port; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

    // RAM registered read port, cleared on reset and flush.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            pf_data_q <= '0;
        end else if (mem_rd) begin
            pf_data_q <= mem[rd_ptr_q];
        end
    end

    // Control state, flags and FWFT output stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_count_q <= '0;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_count_q <= mem_count_d;
            pf_valid_q  <= pf_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_rd_data   = FWFT ? out_data_q : pf_data_q;
    assign o_rd_valid  = FWFT ? out_valid_q : pf_valid_q;
    assign o_full      = full_q;
    assign o_afull     = afull_q;
    assign o_empty     = empty_q;
    assign o_aempty    = aempty_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: doc/result_buffer.md
# result_buffer

Parametrised successor of the compute-engine result FIFO: a single-clock, BRAM-backed buffer between the compute engine and the host/testbench read path. Width, depth and thresholds are generic. It adds a first-word-fall-through (FWFT) read mode, a synchronous flush, an almost-empty flag, a read-valid strobe and sticky overflow/underflow error flags. Flags and count are exact: each reflects the accepted operations of the previous edge, with no extra lag.

## Interface
Parameters:
- DATA_WIDTH, 16: word width (FP16 results by default).
- DEPTH, 4096: entries; power of two, ≥ 4.
- AFULL_THRESHOLD, DEPTH-256: o_afull asserts when count ≥ this value.
- AEMPTY_THRESHOLD, 4: o_aempty asserts when count ≤ this value.
- FWFT, 0: 0 = standard 1-cycle read latency; 1 = first-word-fall-through.
- COUNT_WIDTH, $clog2(DEPTH)+1: width of o_count.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous empty-the-buffer request.
- i_wr_data  in  DATA_WIDTH  write word.
- i_wr_en  in  1  write request.
- o_full  out  1  count == DEPTH.
- o_afull  out  1  count ≥ AFULL_THRESHOLD.
- i_rd_en  in  1  read request (FWFT: pop/acknowledge of head word).
- o_rd_data  out  DATA_WIDTH  read word.
- o_rd_valid  out  1  o_rd_data holds a valid word.
- o_empty  out  1  count == 0.
- o_aempty  out  1  count ≤ AEMPTY_THRESHOLD.
- o_count  out  COUNT_WIDTH  words held, including any FWFT output stage.
- o_overflow  out  1  sticky: a write was rejected.
- o_underflow  out  1  sticky: a read was rejected.
- i_clr_err  in  1  clears both sticky flags.

## Operation
- Write acceptance: wr_acc = i_wr_en & !full & !i_flush, where full is the registered count == DEPTH. A read in the same cycle does not rescue a write to a full buffer.
- Read acceptance, standard mode: rd_acc = i_rd_en & !empty & !i_flush. A write in the same cycle does not rescue a read from an empty buffer.
- Read acceptance, FWFT mode: rd_acc = i_rd_en & o_rd_valid & !i_flush.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count: +1 on write only, -1 on read only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- All flags are registered and computed from the next-state count, so they always agree with o_count in the same cycle.
- Standard mode: on rd_acc at edge N, o_rd_data = mem[rd_ptr] after edge N and o_rd_valid pulses for exactly that one cycle. o_rd_data holds its value when there is no read.
- FWFT mode:
  - Head word is presented on o_rd_data with o_rd_valid high. o_empty = (count == 0).
  - The implementation uses an output register plus a one-entry prefetch stage and must sustain one pop per cycle indefinitely.
  - Words in the prefetch and output stages are included in count.
- Errors:
  - i_wr_en while full (flush inactive) sets o_overflow at the next edge.
  - A rejected i_rd_en (flush inactive) sets o_underflow at the next edge.
  - i_clr_err clears both flags. If a set and a clear occur in the same cycle, the set wins.
- Flush: at the edge where i_flush is sampled, the following clear to 0: pointers, count, prefetch/output valid, o_rd_valid, o_rd_data. Flags go to their empty values. Requests in that cycle are ignored and do not set error flags. Memory contents are don't-care.
- Priority: i_reset > i_flush > normal operation.

## Timing
- Reset values: o_full 0, o_afull 0, o_empty 1, o_aempty 1, o_count 0, o_rd_data 0, o_rd_valid 0, o_overflow 0, o_underflow 0.
- Reset mid-operation: every output takes its reset value at the next edge; buffered data is lost.
- Standard mode read latency: 1 cycle from i_rd_en to o_rd_data/o_rd_valid.
- FWFT, write into an empty buffer: write accepted at edge N, o_rd_valid high after edge N+2 (2-cycle fall-through).
- FWFT pop: pop at edge N with more data buffered presents the next word after edge N.
- Flag and count update: at the same edge as the accepted operation. Example: the first accepted write drops o_empty after that edge.
- Throughput: one write and one read per cycle in both modes.

## Test plan
- Reset, then 5 writes of 0x3C00+i, then 5 reads (FWFT=0): read data arrives 1 cycle after each i_rd_en in order 0x3C00..0x3C04, o_rd_valid pulses 5 times, count 5→0, o_empty=1 at end.
- Fill with DEPTH=16 and AFULL_THRESHOLD=12: o_afull rises after the 12th write and o_full after the 16th. A 17th write is dropped, o_overflow=1, count stays 16. i_clr_err then clears o_overflow.
- Wrap-around, DEPTH=16: run 40 writes and 40 reads interleaved at half depth with simultaneous rd/wr. Data order is preserved across the pointer wrap and count stays constant in simultaneous cycles.
- FWFT=1: a write of 0xABCD into an empty buffer gives o_rd_valid=1 with 0xABCD two edges later. Continuous pops over a 32-word burst deliver one word per cycle with no bubble.
- Read when empty: i_rd_en with simultaneous i_wr_en on an empty buffer rejects the read and sets o_underflow=1. The write is accepted, giving count=1.
- i_flush with 8 words held and i_wr_en high: count=0, o_empty=1, o_rd_valid=0 next cycle, no error flags set. A subsequent write/read returns the new data only.
